// File: rtl/fetch_controller.sv
// Instruction fetch controller: IDLE/REQ/ISSUE handshake with instruction memory and redirect handling.
// Optional build macro FETCH_MISALIGN_TRAP_EN flags misaligned redirect targets and aligns them.
module fetch_controller #(
    parameter int unsigned         BITWIDTH = 32,
    parameter logic [BITWIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_decision,
    input  logic [BITWIDTH-1:0] branch_target,
    output logic                imem_req,
    output logic [BITWIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic                inst_valid,
    output logic [31:0]         inst,
    output logic [BITWIDTH-1:0] inst_pc,
    output logic [BITWIDTH-1:0] pc,
    output logic                misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BITWIDTH-1:0] pc_q, pc_d;
    logic                pend_q, pend_d;
    logic [BITWIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic [31:0]         inst_q, inst_d;
    logic [BITWIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                valid_q, valid_d;
    logic                redirect;
    logic [BITWIDTH-1:0] target_eff;

    // A branch only takes effect while a fetch is in flight or an instruction is on offer.
    assign redirect = branch_decision && (state_q == REQ || state_q == ISSUE);

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect && (branch_target[1:0] != 2'b00);
        end
    end

    assign misalign   = misalign_q;
    assign target_eff = {branch_target[BITWIDTH-1:2], 2'b00};
`else
    assign misalign   = 1'b0;
    assign target_eff = branch_target;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        valid_d    = valid_q;

        case (state_q)
            IDLE: state_d = REQ;

            REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d   = target_eff;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        // Request belonged to the abandoned path: drop its data, refetch at the target.
                        pc_d   = pend_tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        state_d   = ISSUE;
                        inst_d    = imem_rdata;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + BITWIDTH'(4);
                    end
                end else if (redirect) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = target_eff;
                end
            end

            ISSUE: begin
                if (redirect) begin
                    valid_d = 1'b0;
                    pc_d    = target_eff;
                    state_d = REQ;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign imem_req   = (state_q == REQ);
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;

endmodule
